result_streamer: RTL

Sequences readback of the filtered image from output memory to the UART transmitter once the kernel run completes. It owns the output-memory read address during the send phase and fetches each byte with a fixed read latency. It issues one-cycle transmit strobes, waits for the transmitter's completion pulse before fetching the next byte, and honours host flow control. It replaces the ad-hoc shared counter plus start_send path between the top-level FSM, output RAM and uart_tx.

---
 rtl/result_streamer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/result_streamer.sv
// result_streamer
//   Streams a finished image from output memory to the UART transmitter.
//   The block owns the output-memory read address while sending and fetches
//   one byte at a time. Each fetch waits a fixed read latency. The byte goes
//   out as a one-cycle strobe, and the next fetch waits for the transmitter's
//   completion pulse. Host flow control (pause) only holds back new bytes.
//
// Optional build macro: CHECKSUM_EN
//   When defined, a running XOR of all data bytes is appended as one extra
//   byte after the last data byte. For len=0 that byte is 0x00.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, len        one-cycle run request, byte count latched on acceptance
//   pause             host not ready; blocks the next strobe only
//   mem_addr          output-memory read address
//   mem_rd_data       read data, valid RD_LATENCY cycles after mem_addr
//   tx_dv, tx_byte    transmit strobe and registered byte to uart_tx
//   tx_active         transmitter busy
//   tx_done           transmitter completion pulse
//   busy, done        run in progress / one-cycle completion pulse
//   sent_count        data bytes fully transmitted in current or last run
module result_streamer #(
  parameter int ADDR_BITS  = 9,
  parameter int LEN_BITS   = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_BITS-1:0]  len,
  input  logic                 pause,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_rd_data,
  output logic                 tx_dv,
  output logic [7:0]           tx_byte,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_BITS-1:0]  sent_count
);

  localparam int LAT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_SEND,
    S_WAIT_TX,
    S_FINISH
`ifdef CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [LEN_BITS-1:0]  sent_q, sent_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
`ifdef CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
  logic                 csum_phase_q, csum_phase_d;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sent_d    = sent_q;
    lat_d     = lat_q;
`ifdef CHECKSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // busy_q is still high during the done cycle, so a start that
        // coincides with done is dropped here.
        if (start && !busy_q) begin
          len_d  = len;
          sent_d = '0;
          addr_d = '0;
          busy_d = 1'b1;
`ifdef CHECKSUM_EN
          csum_d       = '0;
          csum_phase_d = 1'b0;
          state_d      = (len == '0) ? S_CSUM : S_FETCH;
`else
          state_d      = (len == '0) ? S_FINISH : S_FETCH;
`endif
        end
      end
      S_FETCH: begin
        lat_d   = LAT_W'(1);
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (lat_q == LAT_W'(RD_LATENCY)) begin
          tx_byte_d = mem_rd_data;
          state_d   = S_SEND;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_SEND: begin
        if (!pause && !tx_active) begin
          tx_dv_d = 1'b1;
          state_d = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (tx_done) begin
`ifdef CHECKSUM_EN
          if (csum_phase_q) begin
            state_d = S_FINISH;
          end else begin
            sent_d = sent_q + LEN_BITS'(1);
            csum_d = csum_q ^ tx_byte_q;
            if (sent_q + LEN_BITS'(1) == len_q) begin
              state_d = S_CSUM;
            end else begin
              addr_d  = addr_q + ADDR_BITS'(1);
              state_d = S_FETCH;
            end
          end
`else
          sent_d = sent_q + LEN_BITS'(1);
          if (sent_q + LEN_BITS'(1) == len_q) begin
            state_d = S_FINISH;
          end else begin
            // Address wraps silently when len exceeds the memory depth.
            addr_d  = addr_q + ADDR_BITS'(1);
            state_d = S_FETCH;
          end
`endif
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        tx_byte_d    = csum_q;
        csum_phase_d = 1'b1;
        state_d      = S_SEND;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
`ifdef CHECKSUM_EN
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sent_q    <= sent_d;
`ifdef CHECKSUM_EN
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  // Run-scoped values: always initialised on an accepted start before use.
  always_ff @(posedge clk) begin
    len_q <= len_d;
    lat_q <= lat_d;
`ifdef CHECKSUM_EN
    csum_q <= csum_d;
`endif
  end

  assign mem_addr   = addr_q;
  assign tx_dv      = tx_dv_q;
  assign tx_byte    = tx_byte_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = sent_q;

endmodule
